// File: rtl/core_hazard_ctrl.sv
// Scoreboard issue controller between decode and execute: tracks pending register
// writes and total in-flight count, and stalls decode on RAW, write saturation and serialization.
module core_hazard_ctrl #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2,
  parameter bit WB_BYPASS    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_valid,
  input  logic        d_want_rs1,
  input  logic [4:0]  d_rs1,
  input  logic        d_want_rs2,
  input  logic [4:0]  d_rs2,
  input  logic        d_reg_wen,
  input  logic [4:0]  d_rd,
  input  logic        d_serialize,
  input  logic        x_ready,
  input  logic        br_flush,
  input  logic        w_fire,
  input  logic        w_reg_wen,
  input  logic [4:0]  w_rd,
  output logic        d_stall,
  output logic [31:0] sb_pending,
  output logic        sb_busy,
  output logic        sb_err,
  output logic [31:0] stall_cycles,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_SER_WAIT = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Handshake: an instruction moves from decode to execute only on a cycle where
  // d_valid=1, d_stall=0, x_ready=1 and br_flush=0; w_fire marks one retirement.
  logic [CNT_W-1:0] r_cnt [32];
  logic [CNT_W-1:0] r_inflight;
  logic [1:0]       r_state;
  logic             r_err;
  logic [31:0]      r_stall_cycles;

  logic [CNT_W-1:0] w_cnt_nxt [32];
  logic [CNT_W-1:0] w_inflight_nxt;
  logic [1:0]       w_state_nxt;
  logic             w_wb_ret;
  logic             w_byp1;
  logic             w_byp2;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_waw_full;
  logic             w_ser_stall;
  logic             w_issue;
  logic             w_cnt_err;
  logic             w_infl_err;
  logic [31:0]      w_inc_vec;
  logic [31:0]      w_dec_vec;

  assign w_wb_ret = w_fire & w_reg_wen & (w_rd != 5'd0);

  // Write-through register file: the last pending write landing this cycle is readable now.
  assign w_byp1 = WB_BYPASS & w_wb_ret & (w_rd == d_rs1) & (r_cnt[d_rs1] == CNT_ONE);
  assign w_byp2 = WB_BYPASS & w_wb_ret & (w_rd == d_rs2) & (r_cnt[d_rs2] == CNT_ONE);
  assign w_haz1 = d_want_rs1 & (d_rs1 != 5'd0) & (r_cnt[d_rs1] != '0) & ~w_byp1;
  assign w_haz2 = d_want_rs2 & (d_rs2 != 5'd0) & (r_cnt[d_rs2] != '0) & ~w_byp2;

  assign w_waw_full  = d_reg_wen & (d_rd != 5'd0) & (r_cnt[d_rd] == CNT_MAX);
  assign w_ser_stall = (r_state == ST_DRAIN) | (r_state == ST_SER_WAIT) |
                       ((r_state == ST_RUN) & d_serialize & (r_inflight != '0));

  assign d_stall = d_valid & ~br_flush & (w_haz1 | w_haz2 | w_waw_full | w_ser_stall);
  assign w_issue = d_valid & ~d_stall & x_ready & ~br_flush;

  assign w_inc_vec = (w_issue & d_reg_wen) ? (32'd1 << d_rd) : 32'd0;
  assign w_dec_vec = w_wb_ret ? (32'd1 << w_rd) : 32'd0;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_cnt_err = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (w_dec_vec[r]) begin
        if (r_cnt[r] == '0) w_cnt_err = 1'b1;
        else if (!w_inc_vec[r]) w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
      end else if (w_inc_vec[r] && (r_cnt[r] != CNT_MAX)) begin
        w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
      end
    end
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    w_infl_err     = 1'b0;
    if (w_issue && !w_fire) begin
      if (r_inflight == CNT_MAX) w_infl_err = 1'b1;
      else w_inflight_nxt = r_inflight + CNT_ONE;
    end else if (!w_issue && w_fire) begin
      if (r_inflight == '0) w_infl_err = 1'b1;
      else w_inflight_nxt = r_inflight - CNT_ONE;
    end else if (w_issue && w_fire && (r_inflight == '0)) begin
      w_infl_err = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (d_valid && d_serialize && !br_flush && (r_inflight != '0)) w_state_nxt = ST_DRAIN;
        else if (w_issue && d_serialize) w_state_nxt = ST_SER_WAIT;
      end
      ST_DRAIN: begin
        if (br_flush || (w_inflight_nxt == '0)) w_state_nxt = ST_RUN;
      end
      ST_SER_WAIT: begin
        if (w_inflight_nxt == '0) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) r_cnt[r] <= '0;
      r_inflight     <= '0;
      r_state        <= ST_RUN;
      r_err          <= 1'b0;
      r_stall_cycles <= 32'd0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_inflight <= w_inflight_nxt;
      r_state    <= w_state_nxt;
      r_err      <= r_err | w_cnt_err | w_infl_err;
      if (d_stall && (r_stall_cycles != 32'hFFFF_FFFF)) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  always_comb begin
    sb_pending = '0;
    for (int r = 0; r < 32; r++) sb_pending[r] = (r_cnt[r] != '0);
  end

  assign sb_busy      = (r_inflight != '0);
  assign sb_err       = r_err;
  assign stall_cycles = r_stall_cycles;
  assign dbg_state    = r_state;

endmodule

// File: doc/core_hazard_ctrl.md
Name: core_hazard_ctrl

Overview:
- Scoreboard-based issue controller for the 5-stage core (F/D/X/M/W).
- Sits between decode and execute. Tracks in-flight register writes per architectural register and the total number of instructions in flight.
- Drives the decode stall for RAW hazards, write-count saturation and serializing instructions (CSR/fence).
- Handles decode squash on branch flush and keeps a stall-cycle performance counter.

Parameters:
- MAX_INFLIGHT, 3, max instructions in flight past decode (X, M, W); also per-register pending-write limit.
- CNT_W, 2, width of per-register and total in-flight counters; must hold MAX_INFLIGHT.
- WB_BYPASS, 1, 1 = register file is write-through, so a same-cycle W retire clears the hazard.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- d_valid  in  1  decode holds a valid instruction
- d_want_rs1  in  1  instruction reads rs1
- d_rs1  in  5  rs1 address
- d_want_rs2  in  1  instruction reads rs2
- d_rs2  in  5  rs2 address
- d_reg_wen  in  1  instruction writes rd
- d_rd  in  5  rd address
- d_serialize  in  1  instruction must execute with an empty pipeline (CSR, fence)
- x_ready  in  1  execute accepts an instruction this cycle
- br_flush  in  1  branch/jump in X redirects fetch and squashes decode
- w_fire  in  1  an instruction retires from W this cycle
- w_reg_wen  in  1  retiring instruction writes rd
- w_rd  in  5  retiring rd
- d_stall  out  1  hold decode; combinational
- sb_pending  out  32  bit r = counter of register r is nonzero; registered
- sb_busy  out  1  total in-flight count is nonzero
- sb_err  out  1  sticky underflow/overflow error
- stall_cycles  out  32  cycles with d_stall=1; saturating

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - all counters = 0, state = RUN, sb_err = 0, stall_cycles = 0.
  - Outputs after reset: sb_pending = 0, sb_busy = 0, d_stall = 0 unless the hazard conditions below hold.
  - Reset mid-operation discards all scoreboard state.
- Issue: `issue = d_valid & ~d_stall & x_ready & ~br_flush`.
- Retire: `w_fire`. A register write retires when `w_fire & w_reg_wen & w_rd!=0`.
- Per-register counter cnt[r], r=1..31:
  - +1 on issue with `d_reg_wen & d_rd==r`.
  - -1 on a register-write retire with `w_rd==r`.
  - Both in the same cycle: unchanged.
  - cnt[0] is always 0; writes to x0 are ignored.
- Total counter `inflight`:
  - +1 on every issue, -1 on every w_fire; both in the same cycle: unchanged.
- RAW hazard on rsN, when `want_rsN & rsN!=0 & cnt[rsN]!=0`.
  - Exception when WB_BYPASS=1: no hazard if `cnt[rsN]==1` and a register-write retire to rsN occurs this cycle.
- d_stall is 1 when `d_valid & ~br_flush` and any of the following holds:
  - RAW hazard on rs1 or rs2.
  - `d_reg_wen & d_rd!=0 & cnt[d_rd]==MAX_INFLIGHT`.
  - state==DRAIN, or state==RUN with `d_serialize & inflight!=0`.
  - state==SER_WAIT.
- br_flush forces d_stall=0; the squashed decode instruction never issues and touches no counter.
- FSM:
  - RUN:
    - `d_valid & d_serialize & ~br_flush & inflight!=0` -> DRAIN.
    - issue with d_serialize -> SER_WAIT.
  - DRAIN:
    - br_flush -> RUN.
    - inflight==0 (after this cycle's update) -> RUN; the instruction then issues on a later cycle from RUN and moves to SER_WAIT.
  - SER_WAIT: stall all issue; next-cycle inflight==0 -> RUN.
- Errors; sb_err is set and held until reset:
  - A retire when inflight==0: counter stays 0.
  - A register-write retire with cnt[w_rd]==0: counter stays 0.
  - inflight would exceed MAX_INFLIGHT.
- stall_cycles increments each cycle with d_stall=1 and stops at 0xFFFFFFFF.
- sb_pending and sb_busy reflect counters after the last clock edge.

Test Plan:
- Back-to-back dependency: issue `addi x5` (rd=5), next cycle decode reads rs1=5 -> d_stall=1 for 2 cycles while x5 is in X and M. At W retire, same cycle: stall drops with WB_BYPASS=1. stall_cycles=2, sb_pending[5] 1 -> 0.
- x0 rule: issue rd=0, then read rs1=0 -> never stalls; sb_pending stays 0.
- Three writes to x7 issued consecutively -> cnt[7]=3. A 4th write to x7 stalls until the first retires. Issue and retire in the same cycle keep cnt[7]=3.
- Serialize: two ALU ops in flight, CSR in decode -> state DRAIN, stall until inflight=0. CSR issues -> SER_WAIT. The next instruction stalls until the CSR's w_fire, then RUN.
- Flush: hazard stall active, br_flush=1 -> d_stall=0 and no issue. In DRAIN, br_flush -> RUN.
- Error/reset: w_fire with inflight=0 -> sb_err=1, counters stay 0. Assert rst mid-DRAIN -> state RUN, all outputs 0 next cycle.
